immediate_generator: RTL and testbench
======================================

# immediate_generator

Combinational RV32I immediate decoder with a registered copy of its result. It sits in the decode stage after the instruction decoder, which supplies the already-assembled, right-aligned immediate field `raw_imm`. The block sign-extends or shifts that field to the final 32-bit operand according to the instruction opcode. It presents the result combinationally on `imm` and one cycle later on `imm_q`.

## Interface
- No parameters.
- `clk`  in  1  system clock; `imm_q` updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `raw_imm`  in  32  right-aligned immediate field from the decoder; bits above the format's field width are don't-care.
- `opcode`  in  7  instruction bits [6:0].
- `imm`  out  32  combinational final immediate.
- `imm_fmt`  out  3  combinational format code:
  - 0 = none
  - 1 = I
  - 2 = S
  - 3 = B
  - 4 = U
  - 5 = J
  - 6 and 7 are never driven.
- `imm_q`  out  32  `imm` registered on `clk`.

## Operation
Opcode map, RV32I standard encodings:
- I-format (fmt 1), `imm = {{20{raw_imm[11]}}, raw_imm[11:0]}`:
  - JALR 1100111
  - LOAD 0000011
  - ITYPE 0010011
  - FENCE 0001111
  - ENVIRONMENT 1110011
- S-format (fmt 2), `imm = {{20{raw_imm[11]}}, raw_imm[11:0]}`:
  - STORE 0100011
- B-format (fmt 3), `imm = {{19{raw_imm[12]}}, raw_imm[12:0]}`:
  - BRANCH 1100011
  - `raw_imm[0]` is passed through unchanged; it is not forced to 0.
- U-format (fmt 4), `imm = {raw_imm[19:0], 12'b0}`:
  - LUI 0110111
  - AUIPC 0010111
- J-format (fmt 5), `imm = {{11{raw_imm[20]}}, raw_imm[20:0]}`:
  - JAL 1101111
  - `raw_imm[0]` is passed through unchanged.
- All other opcodes, including RTYPE 0110011: `imm = 0`, `imm_fmt = 0`.

Field-width rules:
- `raw_imm` bits above the format's field width never influence `imm`.
- Every opcode is decoded from all 7 bits exactly; there is no partial matching.
- `imm` and `imm_fmt` are purely combinational: there are no latches, and no X propagates for a known `opcode`.

## Timing
- `imm` and `imm_fmt` have zero latency and settle within the same delta as a `raw_imm` or `opcode` change.
- `imm_q` has one-cycle latency: `imm_q <= imm` on every rising `clk` with `reset` low, with no enable.
- While `reset` is high, `imm_q` is 0 immediately, asynchronously and without a clock edge.
- `reset` has no effect on `imm` or `imm_fmt`.
- Reset release: the first rising edge with `reset` low loads the current `imm`.
- Reset asserted mid-stream: `imm_q` drops to 0 at once, and the captured value is lost.
- Reset value of every registered output: `imm_q = 32'h0`.

## Test plan
- I-format:
  - JALR, raw 32'd1972 -> `imm` 0x000007B4, fmt 1.
  - LOAD, raw -32'd1121 -> 0xFFFFFB9F.
  - ENVIRONMENT, raw -32'd2025 -> 0xFFFFF817.
  - FENCE, raw 0 -> 0x00000000.
  - ITYPE, raw 0x12345ABC -> 0xFFFFFABC (upper garbage ignored).
- S/B/J:
  - STORE with 1972 / -1121 -> 0x000007B4 / 0xFFFFFB9F, fmt 2.
  - BRANCH with the same -> same values, fmt 3.
  - JAL with the same -> same values, fmt 5.
  - BRANCH, raw 0x00001000 -> 0xFFFFF000.
- U-format:
  - LUI, raw 0x0000BEEF -> 0x0BEEF000, fmt 4.
  - AUIPC, raw 0xDEADBEEF -> 0xDBEEF000.
- Non-immediate:
  - RTYPE with raw 1972 or -1121 -> 0x00000000, fmt 0.
  - opcode 0000000 -> 0x00000000, fmt 0.
- Registered path:
  - Hold `reset` high -> `imm_q` = 0 across edges.
  - Release, drive LUI 0x0000BEEF -> `imm_q` = 0x0BEEF000 after the next rising edge, not before.
  - Assert `reset` between edges -> `imm_q` = 0 immediately.

Source files
------------

// File: rtl/immediate_generator.sv
// immediate_generator: RV32I immediate decoder for the decode stage.
// Turns the decoder's right-aligned immediate field into the final 32-bit
// operand by sign-extending or shifting it according to the opcode. The
// result is also held in a register for the next pipeline stage.
//
// Ports:
//   clk      in   1   system clock, imm_q updates on the rising edge
//   reset    in   1   asynchronous active-high reset, clears imm_q only
//   raw_imm  in  32   right-aligned immediate field; bits above the field are ignored
//   opcode   in   7   instruction bits [6:0]
//   imm      out 32   combinational final immediate
//   imm_fmt  out  3   combinational format code (0 none, 1 I, 2 S, 3 B, 4 U, 5 J)
//   imm_q    out 32   imm registered on clk
module immediate_generator (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] raw_imm,
  input  logic [6:0]  opcode,
  output logic [31:0] imm,
  output logic [2:0]  imm_fmt,
  output logic [31:0] imm_q
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned FMTW = 3;

  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_ENV    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [FMTW-1:0] FMT_NONE = FMTW'(0);
  localparam logic [FMTW-1:0] FMT_I    = FMTW'(1);
  localparam logic [FMTW-1:0] FMT_S    = FMTW'(2);
  localparam logic [FMTW-1:0] FMT_B    = FMTW'(3);
  localparam logic [FMTW-1:0] FMT_U    = FMTW'(4);
  localparam logic [FMTW-1:0] FMT_J    = FMTW'(5);

  // Full 7-bit opcode match selects the format; unknown opcodes give zero.
  always_comb begin
    imm     = '0;
    imm_fmt = FMT_NONE;
    case (opcode)
      OP_JALR, OP_LOAD, OP_ITYPE, OP_FENCE, OP_ENV: begin
        imm_fmt = FMT_I;
        imm     = {{20{raw_imm[11]}}, raw_imm[11:0]};
      end
      OP_STORE: begin
        imm_fmt = FMT_S;
        imm     = {{20{raw_imm[11]}}, raw_imm[11:0]};
      end
      OP_BRANCH: begin
        // bit 0 is passed through; the decoder already aligned the offset
        imm_fmt = FMT_B;
        imm     = {{19{raw_imm[12]}}, raw_imm[12:0]};
      end
      OP_LUI, OP_AUIPC: begin
        imm_fmt = FMT_U;
        imm     = {raw_imm[19:0], 12'b0};
      end
      OP_JAL: begin
        imm_fmt = FMT_J;
        imm     = {{11{raw_imm[20]}}, raw_imm[20:0]};
      end
      default: begin
        imm_fmt = FMT_NONE;
        imm     = '0;
      end
    endcase
  end

  // Pipeline copy of the immediate, no enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) imm_q <= XLEN'(0);
    else       imm_q <= imm;
  end

endmodule

// File: tb/tb_immediate_generator.sv
// tb_immediate_generator: directed vector bench for immediate_generator.
// Applies a table of {opcode, raw_imm, expected imm, expected fmt} records,
// checks the combinational outputs and the registered copy, then runs
// hand-written reset sequences for the registered path.
module tb_immediate_generator;

  logic        clk;
  logic        reset;
  logic [31:0] raw_imm;
  logic [6:0]  opcode;
  logic [31:0] imm;
  logic [2:0]  imm_fmt;
  logic [31:0] imm_q;

  int n_vec;
  int n_err;

  immediate_generator dut (
    .clk     (clk),
    .reset   (reset),
    .raw_imm (raw_imm),
    .opcode  (opcode),
    .imm     (imm),
    .imm_fmt (imm_fmt),
    .imm_q   (imm_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] raw;
    logic [31:0] exp_imm;
    logic [2:0]  exp_fmt;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // I-format
    vecs[0]  = '{7'b1100111, 32'd1972,     32'h000007B4, 3'd1};
    vecs[1]  = '{7'b0000011, -32'd1121,    32'hFFFFFB9F, 3'd1};
    vecs[2]  = '{7'b1110011, -32'd2025,    32'hFFFFF817, 3'd1};
    vecs[3]  = '{7'b0001111, 32'd0,        32'h00000000, 3'd1};
    vecs[4]  = '{7'b0010011, 32'h12345ABC, 32'hFFFFFABC, 3'd1};
    vecs[5]  = '{7'b0010011, 32'h00000800, 32'hFFFFF800, 3'd1};
    vecs[6]  = '{7'b0000011, 32'hFFFFF7FF, 32'h000007FF, 3'd1};
    // S-format
    vecs[7]  = '{7'b0100011, 32'd1972,     32'h000007B4, 3'd2};
    vecs[8]  = '{7'b0100011, -32'd1121,    32'hFFFFFB9F, 3'd2};
    vecs[9]  = '{7'b0100011, 32'hABCDE7FF, 32'h000007FF, 3'd2};
    // B-format
    vecs[10] = '{7'b1100011, 32'd1972,     32'h000007B4, 3'd3};
    vecs[11] = '{7'b1100011, -32'd1121,    32'hFFFFFB9F, 3'd3};
    vecs[12] = '{7'b1100011, 32'h00001000, 32'hFFFFF000, 3'd3};
    vecs[13] = '{7'b1100011, 32'hFFFFEFFF, 32'h00000FFF, 3'd3};
    // J-format
    vecs[14] = '{7'b1101111, 32'd1972,     32'h000007B4, 3'd5};
    vecs[15] = '{7'b1101111, -32'd1121,    32'hFFFFFB9F, 3'd5};
    vecs[16] = '{7'b1101111, 32'h00100000, 32'hFFF00000, 3'd5};
    vecs[17] = '{7'b1101111, 32'hFFEFFFFF, 32'h000FFFFF, 3'd5};
    // U-format
    vecs[18] = '{7'b0110111, 32'h0000BEEF, 32'h0BEEF000, 3'd4};
    vecs[19] = '{7'b0010111, 32'hDEADBEEF, 32'hDBEEF000, 3'd4};
    vecs[20] = '{7'b0110111, 32'h000FFFFF, 32'hFFFFF000, 3'd4};
    // No immediate, including one-bit near misses of valid opcodes
    vecs[21] = '{7'b0110011, 32'd1972,     32'h00000000, 3'd0};
    vecs[22] = '{7'b0110011, -32'd1121,    32'h00000000, 3'd0};
    vecs[23] = '{7'b0000000, 32'hFFFFFFFF, 32'h00000000, 3'd0};
    vecs[24] = '{7'b1100110, 32'hFFFFFFFF, 32'h00000000, 3'd0};
    vecs[25] = '{7'b1101011, 32'hFFFFFFFF, 32'h00000000, 3'd0};
    vecs[26] = '{7'b0100111, 32'hFFFFFFFF, 32'h00000000, 3'd0};
    vecs[27] = '{7'b1111111, 32'hFFFFFFFF, 32'h00000000, 3'd0};

    // Reset held: imm_q stays 0 across edges, imm unaffected.
    reset   = 1'b1;
    opcode  = 7'b0110111;
    raw_imm = 32'h0000BEEF;
    #1;
    check("reset_imm_q_t0", imm_q, 32'h0);
    check("reset_imm_passthru", imm, 32'h0BEEF000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_imm_q_held", imm_q, 32'h0);

    // Release at negedge, LUI value appears only after the next rising edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_before_edge", imm_q, 32'h0);
    @(posedge clk);
    #1;
    check("release_first_edge", imm_q, 32'h0BEEF000);

    // Reset between edges clears imm_q at once.
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_imm_q", imm_q, 32'h0);
    check("mid_reset_imm", imm, 32'h0BEEF000);
    @(posedge clk);
    #1;
    check("mid_reset_hold", imm_q, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Vector table: combinational outputs, then the registered copy.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      opcode  = vecs[i].op;
      raw_imm = vecs[i].raw;
      #1;
      check($sformatf("v%0d_imm", i), imm, vecs[i].exp_imm);
      check($sformatf("v%0d_fmt", i), 32'(imm_fmt), 32'(vecs[i].exp_fmt));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_imm_q", i), imm_q, vecs[i].exp_imm);
    end

    // Registered value tracks a change only at the edge.
    @(negedge clk);
    opcode  = 7'b0010111;
    raw_imm = 32'hDEADBEEF;
    #1;
    check("track_before_edge", imm_q, vecs[NV-1].exp_imm);
    @(posedge clk);
    #1;
    check("track_after_edge", imm_q, 32'hDBEEF000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
